// File: rtl/ddr_ring_buffer_ctrl.sv
// Session controller for the DDR ring buffer: geometry latch, timed soft reset, run/drain control.
// Optional registered fill-level interrupt enabled by defining DDR_RB_CTRL_WATERMARK_EN.
module ddr_ring_buffer_ctrl #(
   parameter int AXI_ADDR_WIDTH  = 32,
   parameter int FILL_WIDTH      = 32,
   parameter int SOFT_RST_CYCLES = 16,
   parameter int DRAIN_TIMEOUT   = 65536
) (
   input  logic                      S_AXI_ACLK,
   input  logic                      S_AXI_ARESETN,
   input  logic                      CFG_START,
   input  logic                      CFG_STOP,
   input  logic [31:0]               CFG_RING_LEN,
   input  logic [AXI_ADDR_WIDTH-1:0] CFG_BASE_ADDR,
   input  logic [AXI_ADDR_WIDTH-1:0] CFG_ADDR_MASK,
   input  logic [FILL_WIDTH-1:0]     CFG_WATERMARK,
   input  logic                      DDR_EOB,
   input  logic                      EMPTY,
   input  logic                      DATA_LOSS,
   input  logic [FILL_WIDTH-1:0]     CORE_FILL,
   output logic [31:0]               RING_BUFFER_LEN,
   output logic [AXI_ADDR_WIDTH-1:0] AXI_BASE_ADDR,
   output logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_MASK,
   output logic                      SOFT_RSTN,
   output logic                      CLEAR_EOB,
   output logic                      STREAM_EN,
   output logic                      BUSY,
   output logic                      DONE,
   output logic                      ERROR,
   output logic [31:0]               EOB_COUNT,
   output logic                      WATERMARK_IRQ
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SRST  = 3'd1,
      ST_ARM   = 3'd2,
      ST_RUN   = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [31:0] SRST_LAST  = 32'(SOFT_RST_CYCLES - 1);
   localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_TIMEOUT - 1);

   state_t                    state_q, state_d;
   logic [31:0]               cnt_q, cnt_d;
   logic                      empty_prev_q, empty_prev_d;
   logic [31:0]               ring_len_q, ring_len_d;
   logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
   logic [AXI_ADDR_WIDTH-1:0] mask_q, mask_d;
   logic                      error_q, error_d;
   logic                      clear_eob_q, clear_eob_d;
   logic [31:0]               eob_cnt_q, eob_cnt_d;
   logic                      soft_rstn_q, stream_en_q, busy_q, done_q;
   logic                      active_s, eob_hit_s;

   // An EOB is only taken when no acknowledge is in flight, so the ack cycle never recounts.
   assign active_s  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign eob_hit_s = DDR_EOB & ~clear_eob_q;

   // Next-state and datapath update.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      empty_prev_d = empty_prev_q;
      ring_len_d   = ring_len_q;
      base_d       = base_q;
      mask_d       = mask_q;
      error_d      = error_q;
      clear_eob_d  = 1'b0;
      eob_cnt_d    = eob_cnt_q;

      if (active_s) begin
         if (eob_hit_s) begin
            eob_cnt_d   = eob_cnt_q + 32'd1;
            clear_eob_d = 1'b1;
         end else begin
            eob_cnt_d   = eob_cnt_q;
         end
         if (DATA_LOSS) begin
            error_d = 1'b1;
         end else begin
            error_d = error_q;
         end
      end else begin
         clear_eob_d = 1'b0;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (CFG_START) begin
               if (CFG_RING_LEN != 32'd0) begin
                  ring_len_d = CFG_RING_LEN;
                  base_d     = CFG_BASE_ADDR;
                  mask_d     = CFG_ADDR_MASK;
                  error_d    = 1'b0;
                  cnt_d      = 32'd0;
                  state_d    = ST_SRST;
               end else begin
                  error_d    = 1'b1;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_SRST: begin
            if (cnt_q == SRST_LAST) begin
               cnt_d   = 32'd0;
               state_d = ST_ARM;
            end else begin
               cnt_d   = cnt_q + 32'd1;
            end
         end
         ST_ARM: begin
            eob_cnt_d = 32'd0;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            if (CFG_STOP || DATA_LOSS) begin
               cnt_d        = 32'd0;
               empty_prev_d = 1'b0;
               state_d      = ST_DRAIN;
            end else begin
               state_d      = ST_RUN;
            end
         end
         ST_DRAIN: begin
            // Drain completes on two consecutive EMPTY samples seen inside DRAIN.
            empty_prev_d = EMPTY;
            if (EMPTY && empty_prev_q) begin
               state_d = ST_DONE;
            end else if (cnt_q == DRAIN_LAST) begin
               error_d = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d   = cnt_q + 32'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs, the latter decoded from the next state.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 32'd0;
         empty_prev_q <= 1'b0;
         ring_len_q   <= 32'd0;
         base_q       <= '0;
         mask_q       <= '0;
         error_q      <= 1'b0;
         clear_eob_q  <= 1'b0;
         eob_cnt_q    <= 32'd0;
         soft_rstn_q  <= 1'b1;
         stream_en_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         empty_prev_q <= empty_prev_d;
         ring_len_q   <= ring_len_d;
         base_q       <= base_d;
         mask_q       <= mask_d;
         error_q      <= error_d;
         clear_eob_q  <= clear_eob_d;
         eob_cnt_q    <= eob_cnt_d;
         soft_rstn_q  <= (state_d != ST_SRST);
         stream_en_q  <= (state_d == ST_RUN);
         busy_q       <= (state_d != ST_IDLE) && (state_d != ST_DONE);
         done_q       <= (state_d == ST_DONE);
      end
   end

`ifdef DDR_RB_CTRL_WATERMARK_EN
   logic wm_irq_q;

   // Fill-level interrupt, only meaningful while data is flowing or draining.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         wm_irq_q <= 1'b0;
      end else begin
         wm_irq_q <= active_s && (CORE_FILL >= CFG_WATERMARK);
      end
   end

   assign WATERMARK_IRQ = wm_irq_q;
`else
   logic unused_fill_s;
   assign unused_fill_s = ^{CORE_FILL, CFG_WATERMARK};
   assign WATERMARK_IRQ = 1'b0;
`endif

   assign RING_BUFFER_LEN = ring_len_q;
   assign AXI_BASE_ADDR   = base_q;
   assign AXI_ADDR_MASK   = mask_q;
   assign SOFT_RSTN       = soft_rstn_q;
   assign CLEAR_EOB       = clear_eob_q;
   assign STREAM_EN       = stream_en_q;
   assign BUSY            = busy_q;
   assign DONE            = done_q;
   assign ERROR           = error_q;
   assign EOB_COUNT       = eob_cnt_q;

endmodule

// File: tb/tb_ddr_ring_buffer_ctrl.sv
// Bench for ddr_ring_buffer_ctrl: timestamp-based session model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with a mid-session reset.
module tb_ddr_ring_buffer_ctrl;
   localparam int AW  = 32;
   localparam int FW  = 32;
   localparam int NSR = 16;
   localparam int DTO = 100;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          CFG_START, CFG_STOP, DDR_EOB, EMPTY, DATA_LOSS;
   logic [31:0]   CFG_RING_LEN;
   logic [AW-1:0] CFG_BASE_ADDR, CFG_ADDR_MASK;
   logic [FW-1:0] CFG_WATERMARK, CORE_FILL;
   logic [31:0]   RING_BUFFER_LEN, EOB_COUNT;
   logic [AW-1:0] AXI_BASE_ADDR, AXI_ADDR_MASK;
   logic          SOFT_RSTN, CLEAR_EOB, STREAM_EN, BUSY, DONE, ERROR, WATERMARK_IRQ;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // model: a session is described by its start cycle and drain-entry cycle
   bit            m_sess, m_drain, m_done, m_err, m_clr, m_wm;
   int            m_now, m_start, m_dstart, m_streak;
   logic [31:0]   m_eobs, m_len;
   logic [AW-1:0] m_base, m_mask;

   ddr_ring_buffer_ctrl #(
      .AXI_ADDR_WIDTH(AW), .FILL_WIDTH(FW), .SOFT_RST_CYCLES(NSR), .DRAIN_TIMEOUT(DTO)
   ) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .CFG_START(CFG_START), .CFG_STOP(CFG_STOP), .CFG_RING_LEN(CFG_RING_LEN),
      .CFG_BASE_ADDR(CFG_BASE_ADDR), .CFG_ADDR_MASK(CFG_ADDR_MASK), .CFG_WATERMARK(CFG_WATERMARK),
      .DDR_EOB(DDR_EOB), .EMPTY(EMPTY), .DATA_LOSS(DATA_LOSS), .CORE_FILL(CORE_FILL),
      .RING_BUFFER_LEN(RING_BUFFER_LEN), .AXI_BASE_ADDR(AXI_BASE_ADDR), .AXI_ADDR_MASK(AXI_ADDR_MASK),
      .SOFT_RSTN(SOFT_RSTN), .CLEAR_EOB(CLEAR_EOB), .STREAM_EN(STREAM_EN), .BUSY(BUSY),
      .DONE(DONE), .ERROR(ERROR), .EOB_COUNT(EOB_COUNT), .WATERMARK_IRQ(WATERMARK_IRQ)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_sess = 1'b0; m_drain = 1'b0; m_done = 1'b0; m_err = 1'b0; m_clr = 1'b0; m_wm = 1'b0;
      m_start = 0; m_dstart = 0; m_streak = 0;
      m_eobs = 32'd0; m_len = 32'd0; m_base = '0; m_mask = '0;
   endtask

   // Consumes the inputs of cycle m_now and advances to the next cycle.
   task automatic model_step();
      int d;
      bit run_now, drain_now, clr_nx;
      d         = m_now - m_start;
      run_now   = m_sess && !m_drain && (d >= NSR + 2);
      drain_now = m_sess && m_drain;
      clr_nx    = 1'b0;
`ifdef DDR_RB_CTRL_WATERMARK_EN
      m_wm = (run_now || drain_now) && (CORE_FILL >= CFG_WATERMARK);
`else
      m_wm = 1'b0;
`endif
      if (!m_sess) begin
         if (CFG_START) begin
            if (CFG_RING_LEN != 32'd0) begin
               m_len = CFG_RING_LEN; m_base = CFG_BASE_ADDR; m_mask = CFG_ADDR_MASK;
               m_err = 1'b0; m_done = 1'b0; m_sess = 1'b1; m_drain = 1'b0; m_start = m_now;
            end else begin
               m_err = 1'b1;
            end
         end
      end else begin
         if (!m_drain && d == NSR + 1) m_eobs = 32'd0;
         if (run_now || drain_now) begin
            if (DDR_EOB && !m_clr) begin
               m_eobs = m_eobs + 32'd1;
               clr_nx = 1'b1;
            end
            if (DATA_LOSS) m_err = 1'b1;
         end
         if (run_now && (CFG_STOP || DATA_LOSS)) begin
            m_drain = 1'b1; m_dstart = m_now + 1; m_streak = 0;
         end else if (drain_now) begin
            m_streak = EMPTY ? m_streak + 1 : 0;
            if (m_streak >= 2) begin
               m_sess = 1'b0; m_done = 1'b1;
            end else if (m_now - m_dstart + 1 >= DTO) begin
               m_err = 1'b1; m_sess = 1'b0; m_done = 1'b1;
            end
         end
      end
      m_clr = clr_nx;
      m_now++;
   endtask

   function automatic bit in_srst();
      return m_sess && !m_drain && (m_now - m_start >= 1) && (m_now - m_start <= NSR);
   endfunction

   function automatic bit in_run();
      return m_sess && !m_drain && (m_now - m_start >= NSR + 2);
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ring_len", RING_BUFFER_LEN, m_len);
         chk("base", AXI_BASE_ADDR, m_base);
         chk("mask", AXI_ADDR_MASK, m_mask);
         chk("soft_rstn", SOFT_RSTN, !in_srst());
         chk("stream_en", STREAM_EN, in_run());
         chk("clear_eob", CLEAR_EOB, m_clr);
         chk("busy", BUSY, m_sess);
         chk("done", DONE, m_done);
         chk("error", ERROR, m_err);
         chk("eob_count", EOB_COUNT, m_eobs);
         chk("wm_irq", WATERMARK_IRQ, m_wm);
      end
   end

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
   endtask

   task automatic start_session(input logic [31:0] len);
      CFG_START = 1'b1; CFG_RING_LEN = len;
      CFG_BASE_ADDR = $urandom; CFG_ADDR_MASK = $urandom;
      tick();
      CFG_START = 1'b0;
   endtask

   task automatic async_reset();
      chk_en = 1'b0;
      rst_n  = 1'b0;
      model_reset();
      #1;
      chk("arst_soft_rstn", SOFT_RSTN, 1'b1);
      chk("arst_stream", STREAM_EN, 1'b0);
      chk("arst_busy", BUSY, 1'b0);
      chk("arst_eob_count", EOB_COUNT, 32'd0);
      repeat (3) tick();
      rst_n  = 1'b1;
      chk_en = 1'b1;
   endtask

   initial begin
      int w;
      logic wm_exp;
      CFG_START = 1'b0; CFG_STOP = 1'b0; DDR_EOB = 1'b0; EMPTY = 1'b0; DATA_LOSS = 1'b0;
      CFG_RING_LEN = 32'd0; CFG_BASE_ADDR = '0; CFG_ADDR_MASK = '0;
      CFG_WATERMARK = 32'd64; CORE_FILL = 32'd0;
      m_now = 0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_soft_rstn", SOFT_RSTN, 1'b1);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_done", DONE, 1'b0);
      chk("rst_len", RING_BUFFER_LEN, 32'd0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      tick();

      // zero-length start is refused
      start_session(32'd0);
      chk("zero_len_error", ERROR, 1'b1);
      chk("zero_len_busy", BUSY, 1'b0);
      chk("zero_len_soft_rstn", SOFT_RSTN, 1'b1);
      tick();

      // start with ring length 8: cycle 0 is the start cycle
      start_session(32'd8);
      chk("start_len", RING_BUFFER_LEN, 32'd8);
      chk("start_err_clear", ERROR, 1'b0);
      for (int t = 1; t <= 19; t++) begin
         chk("start_soft_rstn", SOFT_RSTN, (t >= 1 && t <= 16) ? 1'b0 : 1'b1);
         chk("start_stream", STREAM_EN, (t >= 18) ? 1'b1 : 1'b0);
         tick();
      end

      // fill ramp across the watermark
      for (int f = 60; f <= 70; f++) begin
         CORE_FILL = 32'(f);
         tick();
`ifdef DDR_RB_CTRL_WATERMARK_EN
         wm_exp = (f >= 64);
`else
         wm_exp = 1'b0;
`endif
         chk("wm_ramp", WATERMARK_IRQ, wm_exp);
      end
      CORE_FILL = 32'd0;

      // three EOB pulses, each held through the acknowledge cycle
      for (int p = 0; p < 3; p++) begin
         DDR_EOB = 1'b1;
         w = 0;
         do begin
            tick();
            w++;
         end while (!CLEAR_EOB && w < 5);
         chk("eob_ack_seen", CLEAR_EOB, 1'b1);
         tick();
         chk("eob_ack_one_cycle", CLEAR_EOB, 1'b0);
         DDR_EOB = 1'b0;
         tick();
      end
      chk("eob_count_3", EOB_COUNT, 32'd3);

      // stop, EMPTY ten cycles later
      CFG_STOP = 1'b1;
      tick();
      CFG_STOP = 1'b0;
      chk("stop_stream_low", STREAM_EN, 1'b0);
      chk("stop_busy", BUSY, 1'b1);
      repeat (9) tick();
      EMPTY = 1'b1;
      tick();
      chk("drain_done_early", DONE, 1'b0);
      tick();
      chk("drain_done", DONE, 1'b1);
      chk("drain_error", ERROR, 1'b0);
      chk("drain_busy", BUSY, 1'b0);
      EMPTY = 1'b0;
      tick();

      // data loss, EMPTY never arrives: timeout
      start_session(32'd5);
      repeat (20) tick();
      DATA_LOSS = 1'b1;
      tick();
      DATA_LOSS = 1'b0;
      chk("loss_stream_low", STREAM_EN, 1'b0);
      chk("loss_error", ERROR, 1'b1);
      repeat (99) tick();
      chk("timeout_not_yet", DONE, 1'b0);
      tick();
      chk("timeout_done", DONE, 1'b1);
      chk("timeout_error", ERROR, 1'b1);

      // start and stop together from DONE: start wins
      CFG_STOP = 1'b1;
      start_session(32'd3);
      CFG_STOP = 1'b0;
      chk("start_wins_busy", BUSY, 1'b1);
      chk("start_wins_soft_rstn", SOFT_RSTN, 1'b0);

      // randomized traffic
      for (int i = 0; i < 2500; i++) begin
         CFG_START     = ($urandom_range(0, 19) == 0);
         CFG_STOP      = ($urandom_range(0, 29) == 0);
         CFG_RING_LEN  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
         CFG_BASE_ADDR = $urandom;
         CFG_ADDR_MASK = $urandom;
         DDR_EOB       = ($urandom_range(0, 3) == 0);
         EMPTY         = ($urandom_range(0, 2) == 0);
         DATA_LOSS     = ($urandom_range(0, 99) == 0);
         CORE_FILL     = 32'($urandom_range(55, 75));
         if (i == 1234) begin
            async_reset();
         end else begin
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
